// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream load channel between a program host and imem_loader.
//   Signals:
//     in_valid  host -> loader  byte on in_data is valid
//     in_data   host -> loader  program byte (instructions sent high byte first)
//     in_ready  loader -> host  loader accepts the byte this cycle
//   Modports: master (host side), slave (loader side).
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Writable instruction memory with a byte-stream program loader. Pairs of
//   bytes (high first) are written to consecutive words; once the program is
//   sealed by a HALT word (16'h0000) the CPU fetches it through a
//   combinational PC-indexed read port.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     When defined, one extra byte follows the HALT word and must equal the
//     XOR of every preceding byte of the load, otherwise the load fails.
//   Parameters: DEPTH (words, 2..256), AW (PC / counter width)
//   Ports:
//     clk        system clock, rising edge
//     reset_n    asynchronous active-low reset
//     start      one-cycle pulse, begins or restarts a load
//     ld         byte load channel (imem_loader_if.slave)
//     pc         fetch address
//     instr      instruction at pc, combinational, HALT when not fetchable
//     cpu_hold   keeps the CPU in reset while loading
//     done       program sealed and fetchable
//     err        load failed
//     word_count words written in the current or last load
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  imem_loader_if.slave    ld,
  input  logic [AW-1:0]   pc,
  output logic [15:0]     instr,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   word_count
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   word_count_q, word_count_d;
  logic            err_q, err_d;
  logic [7:0]      hi_q, lo_q;
  logic            hi_ld, lo_ld, mem_we, accept;
  logic [AW-1:0]   wc_inc;
  logic [15:0]     mem [DEPTH];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  assign accept = ld.in_valid & ld.in_ready;
  assign wc_inc = word_count_q + 1'b1;

  always_comb begin
    ld.in_ready = (state_q == HI) || (state_q == LO);
    cpu_hold    = (state_q == HI) || (state_q == LO) || (state_q == WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ld.in_ready = ld.in_ready || (state_q == CHK);
    cpu_hold    = cpu_hold || (state_q == CHK);
`endif
  end

  assign done       = (state_q == DONE) && !err_q;
  assign err        = err_q;
  assign word_count = word_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  // start wins over every other transition, including a byte offered in the
  // same cycle.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    hi_ld        = 1'b0;
    lo_ld        = 1'b0;
    mem_we       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    if (start) begin
      state_d      = HI;
      word_count_d = '0;
      err_d        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d        = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        HI: if (accept) begin
          hi_ld   = 1'b1;
          state_d = LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ ld.in_data;
`endif
        end
        LO: if (accept) begin
          lo_ld   = 1'b1;
          state_d = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ ld.in_data;
`endif
        end
        WRITE: begin
          mem_we       = 1'b1;
          word_count_d = wc_inc;
          if ({hi_q, lo_q} == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if ({1'b0, wc_inc} == DEPTH_W) begin
            // Memory full without a HALT: the program cannot be sealed.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = HI;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: if (accept) begin
          err_d   = (ld.in_data != chk_q);
          state_d = DONE;
        end
`endif
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte holding registers and the array carry data only and are not reset.
  always_ff @(posedge clk) begin
    if (hi_ld)  hi_q <= ld.in_data;
    if (lo_ld)  lo_q <= ld.in_data;
    if (mem_we) mem[word_count_q[IW-1:0]] <= {hi_q, lo_q};
  end

  // Fetches outside the sealed program read as HALT.
  always_comb begin
    instr = 16'h0000;
    if (done && (pc < word_count_q)) instr = mem[pc[IW-1:0]];
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream program loader; it replaces the fixed instruction ROM in front of the control unit. A host pushes 16-bit instructions high byte first over a valid/ready byte interface. The block assembles each pair of bytes into a word and writes it at consecutive addresses. Once the loaded program is sealed, the CPU fetches from it through a combinational PC-indexed read port.

## Interface
Parameters:
- DEPTH, 32, number of 16-bit instruction words; range 2..256
- AW, 8, width of the PC and the address counter

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins or restarts a load
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader can accept a byte this cycle
- pc  in  AW  fetch address from control
- instr  out  16  instruction at pc; combinational
- cpu_hold  out  1  holds the CPU in reset while a load is in progress
- done  out  1  program sealed and fetchable
- err  out  1  load failed (overflow, or checksum mismatch when enabled)
- word_count  out  AW  number of words written in the current or last load

## Operation
- States: IDLE, HI, LO, WRITE, CHK, DONE.
- Reset: state=IDLE; in_ready=0, cpu_hold=0, done=0, err=0, word_count=0, instr=16'h0000. Memory array contents are not reset.
- IDLE + start → HI. The same transition clears word_count, err and the checksum accumulator.
- HI: in_ready=1. On a byte accept, latch in_data into hi_byte and go to LO.
- LO: in_ready=1. On a byte accept, latch in_data into lo_byte and go to WRITE.
- WRITE: in_ready=0.
  - mem[word_count] ← {hi_byte, lo_byte}; then word_count increments.
  - If the word is 16'h0000 (HALT): go to CHK if the macro is defined, otherwise to DONE.
  - Else if the incremented word_count equals DEPTH: err=1, go to DONE.
  - Otherwise go to HI.
- CHK: described under Configuration.
- DONE: done=1 only if err=0. Stays in DONE until start or reset; a start re-enters HI and clears done.
- cpu_hold=1 in HI, LO, WRITE and CHK; 0 in IDLE and DONE.
- Read port:
  - instr = mem[pc] when done=1 and pc < word_count.
  - Otherwise instr = 16'h0000 (HALT). An unloaded or failed memory therefore halts the CPU.
- start while in HI, LO, WRITE or CHK aborts the load:
  - word_count=0, err=0, go to HI.
  - A byte presented in the same cycle is ignored.
  - start has priority over every other transition.
- All counter arithmetic is unsigned AW bits. word_count never exceeds DEPTH.

## Timing
- A byte is accepted on a rising edge with in_valid & in_ready. The host holds in_data stable while in_valid=1 and in_ready=0.
- Minimum of 3 cycles per word: HI, LO, WRITE. in_ready drops for exactly the one WRITE cycle.
- The HALT word written in WRITE gives done=1 in the following cycle (no macro). cpu_hold falls in that same cycle.
- instr follows pc in the same cycle: no read latency.
- Asserting reset_n low in any state forces the reset values immediately (asynchronously). A partially written memory is not fetchable, because done=0.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the HALT word, the FSM enters CHK with in_ready=1 and accepts one more byte.
  - That byte must equal the XOR of all preceding bytes of this load. On a match, go to DONE with done=1. On a mismatch, set err=1 and go to DONE with done=0.
- Not defined: the CHK state and the accumulator are absent; HALT goes straight from WRITE to DONE.

## Test plan
- Reset, then start, then bytes 10 00 10 11 00 00 → word_count=3, done=1, err=0. pc=1 gives instr=16'h1011; pc=3 gives 16'h0000.
- Back-to-back valid: in_ready reads 1,1,0 repeating. A byte held through WRITE is accepted in the next HI, with no byte lost or duplicated.
- DEPTH=4, load 4 non-HALT words → err=1, done=0, word_count=4. instr=16'h0000 for every pc.
- start pulsed after 3 bytes, then a full 2-word program → word_count=2. The first word is the new program's first word.
- reset_n low for 1 cycle mid-LO → cpu_hold=0, in_ready=0, done=0 immediately. A subsequent load completes normally.
- With IMEM_LOADER_CHECKSUM_EN: bytes 12 34 00 00 then 26 → done=1. The same load with final byte 27 → err=1, done=0.
